// File: rtl/reg_issue_ctrl_pkg.sv
// Shared sizes and FSM encoding for the register issue controller and its cells.
package reg_issue_ctrl_pkg;

    localparam int LEN_REG   = 32;  // register data width
    localparam int NUM_REG   = 16;  // number of register cells
    localparam int LEN_RADDR = 4;   // register index width
    localparam int NUM_WB    = 2;   // writeback requesters

    // Controller state encoding, kept as plain constants for older consumers.
    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

endpackage

// File: rtl/reg_issue_ctrl_rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last winner (ptr), so a
// source that just won drops to lowest priority on the next request.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic found;

    // Pick the first requester at or after (ptr+1) mod N.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no
        // path leaves it unassigned and no latch is inferred.
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 1; i <= N; i++) begin
            int idx;
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/reg_issue_ctrl.sv
// Register issue controller: stalls issue on RAW/WAW hazards seen through the
// cells' reservation bits, strobes the reservation for each issued destination,
// arbitrates writeback sources into a one-deep registered writeback stage, and
// offers a drain that blocks issue until every reservation has been written back.
// NUM_REG must not exceed 2**LEN_RADDR.
module reg_issue_ctrl
    import reg_issue_ctrl_pkg::*;
#(
    parameter int LEN_REG   = reg_issue_ctrl_pkg::LEN_REG,
    parameter int NUM_REG   = reg_issue_ctrl_pkg::NUM_REG,
    parameter int LEN_RADDR = reg_issue_ctrl_pkg::LEN_RADDR,
    parameter int NUM_WB    = reg_issue_ctrl_pkg::NUM_WB
) (
    input  logic                          clk,
    input  logic                          rst,
    // issue interface
    input  logic                          iss_valid_i,
    output logic                          iss_ready_o,
    input  logic [LEN_RADDR-1:0]          iss_rs0_i,
    input  logic [LEN_RADDR-1:0]          iss_rs1_i,
    input  logic [LEN_RADDR-1:0]          iss_rd_i,
    input  logic                          iss_rd_en_i,
    // register cell reservation handshake
    input  logic [NUM_REG-1:0]            reserve_i,
    output logic [NUM_REG-1:0]            w_reserve_o,
    // writeback sources
    input  logic [NUM_WB-1:0]             wb_valid_i,
    input  logic [NUM_WB*LEN_RADDR-1:0]   wb_rd_i,
    input  logic [NUM_WB*LEN_REG-1:0]     wb_data_i,
    output logic [NUM_WB-1:0]             wb_ready_o,
    // writeback to the cells
    output logic [NUM_REG-1:0]            wb_o,
    output logic [LEN_REG-1:0]            wb_data_o,
    // drain control
    input  logic                          drain_i,
    output logic                          drained_o,
    output logic                          busy_o
);

    localparam int WB_IW = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;
    localparam int CNT_W = LEN_RADDR + 1;

    logic [0:0]           state;
    logic [CNT_W-1:0]     out_cnt;
    logic [WB_IW-1:0]     rr_ptr;

    logic                 hazard;
    logic                 issue_rsv;
    logic                 wb_any;
    logic                 wb_hit;
    logic                 drain_done;
    logic [WB_IW-1:0]     gnt_idx;
    logic [LEN_RADDR-1:0] sel_rd;
    logic [LEN_REG-1:0]   sel_data;
    logic [NUM_REG-1:0]   sel_oh;

    // Hazard decode: sources are always checked; the destination only when written.
    assign hazard = reserve_i[iss_rs0_i] | reserve_i[iss_rs1_i]
                  | (iss_rd_en_i & reserve_i[iss_rd_i]);

    assign iss_ready_o = (state == RUN) & iss_valid_i & ~hazard;
    assign issue_rsv   = iss_ready_o & iss_rd_en_i;

    // One-hot reservation strobe for the destination of the accepted instruction.
    always_comb begin
        w_reserve_o = '0;
        if (issue_rsv) begin
            w_reserve_o[iss_rd_i] = 1'b1;
        end
    end

    rr_arbiter #(
        .N  (NUM_WB),
        .IW (WB_IW)
    ) u_arb (
        .req       (wb_valid_i),
        .ptr       (rr_ptr),
        .grant     (wb_ready_o),
        .grant_idx (gnt_idx)
    );

    assign wb_any = |wb_valid_i;
    assign wb_hit = |wb_o;

    // Select the granted source's destination and data, and decode the destination.
    always_comb begin
        sel_rd   = wb_rd_i[int'(gnt_idx)*LEN_RADDR +: LEN_RADDR];
        sel_data = wb_data_i[int'(gnt_idx)*LEN_REG +: LEN_REG];
        sel_oh   = '0;
        sel_oh[sel_rd] = 1'b1;
    end

    // Writeback stage: one registered writeback per cycle; data holds when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_o      <= '0;
            wb_data_o <= '0;
        end else if (wb_any) begin
            // NOTE: state is updated with non-blocking assignments so every flop
            // samples values from before the edge, independent of block order.
            wb_o      <= sel_oh;
            wb_data_o <= sel_data;
        end else begin
            wb_o      <= '0;
        end
    end

    // Round-robin pointer remembers the last winner; idle cycles leave it alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (wb_any) begin
            rr_ptr <= gnt_idx;
        end
    end

    // Outstanding reservations: up on a reserving issue, down on each writeback,
    // never below zero (a writeback to an unreserved register is still applied).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_cnt <= '0;
        end else begin
            if (issue_rsv && !wb_hit) begin
                out_cnt <= out_cnt + CNT_W'(1);
            end else if (!issue_rsv && wb_hit && (out_cnt != '0)) begin
                out_cnt <= out_cnt - CNT_W'(1);
            end
        end
    end

    assign busy_o     = (out_cnt != '0);
    assign drain_done = (state == DRAIN) & (out_cnt == '0) & ~wb_hit;
    assign drained_o  = drain_done;

    // Drain FSM: issue is blocked while draining; writebacks keep flowing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else if (state == RUN) begin
            if (drain_i) begin
                state <= DRAIN;
            end
        end else if (drain_done) begin
            state <= RUN;
        end
    end

endmodule

// File: tb/tb_reg_issue_ctrl.sv
// Self-checking bench for reg_issue_ctrl: directed issue/hazard/drain stimulus,
// with writebacks tracked by a scoreboard queue filled when a grant is expected
// and drained when the registered writeback appears one cycle later.
module tb_reg_issue_ctrl;

    localparam int LR = 32;
    localparam int NR = 16;
    localparam int LA = 4;
    localparam int NW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              iss_valid_i;
    logic              iss_ready_o;
    logic [LA-1:0]     iss_rs0_i;
    logic [LA-1:0]     iss_rs1_i;
    logic [LA-1:0]     iss_rd_i;
    logic              iss_rd_en_i;
    logic [NR-1:0]     reserve_i;
    logic [NR-1:0]     w_reserve_o;
    logic [NW-1:0]     wb_valid_i;
    logic [NW*LA-1:0]  wb_rd_i;
    logic [NW*LR-1:0]  wb_data_i;
    logic [NW-1:0]     wb_ready_o;
    logic [NR-1:0]     wb_o;
    logic [LR-1:0]     wb_data_o;
    logic              drain_i;
    logic              drained_o;
    logic              busy_o;

    typedef struct packed {
        logic [NR-1:0] oh;
        logic [LR-1:0] data;
    } wb_exp_t;

    wb_exp_t sb_q[$];
    int      ptr_m;
    int      n_checks = 0;
    int      n_pass   = 0;

    always #5 clk = ~clk;

    reg_issue_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .iss_valid_i (iss_valid_i),
        .iss_ready_o (iss_ready_o),
        .iss_rs0_i   (iss_rs0_i),
        .iss_rs1_i   (iss_rs1_i),
        .iss_rd_i    (iss_rd_i),
        .iss_rd_en_i (iss_rd_en_i),
        .reserve_i   (reserve_i),
        .w_reserve_o (w_reserve_o),
        .wb_valid_i  (wb_valid_i),
        .wb_rd_i     (wb_rd_i),
        .wb_data_i   (wb_data_i),
        .wb_ready_o  (wb_ready_o),
        .wb_o        (wb_o),
        .wb_data_o   (wb_data_o),
        .drain_i     (drain_i),
        .drained_o   (drained_o),
        .busy_o      (busy_o)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: observed %0h, expected %0h", tag, act, exp);
    endtask

    task automatic set_wb(input int k, input logic v, input logic [LA-1:0] rd, input logic [LR-1:0] d);
        wb_valid_i[k]         = v;
        wb_rd_i[k*LA +: LA]   = rd;
        wb_data_i[k*LR +: LR] = d;
    endtask

    task automatic set_iss(input logic v, input logic [LA-1:0] rs0, input logic [LA-1:0] rs1,
                           input logic [LA-1:0] rd, input logic rd_en);
        iss_valid_i = v;
        iss_rs0_i   = rs0;
        iss_rs1_i   = rs1;
        iss_rd_i    = rd;
        iss_rd_en_i = rd_en;
    endtask

    // Mid-cycle: compare the stage with the scoreboard, then predict this cycle's grant.
    task automatic settle(input string tag);
        wb_exp_t       e;
        logic [NW-1:0] g;
        int            gi;
        bit            found;
        @(negedge clk);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, " wb_o"}, 64'(wb_o), 64'(e.oh));
            check({tag, " wb_data_o"}, 64'(wb_data_o), 64'(e.data));
        end else begin
            check({tag, " wb_o idle"}, 64'(wb_o), 64'd0);
        end
        g = '0; gi = 0; found = 1'b0;
        for (int i = 1; i <= NW; i++) begin
            int k;
            k = (ptr_m + i) % NW;
            if (!found && wb_valid_i[k]) begin
                found = 1'b1;
                g[k]  = 1'b1;
                gi    = k;
            end
        end
        check({tag, " wb_ready_o"}, 64'(wb_ready_o), 64'(g));
        if (found) begin
            e.oh   = NR'(1) << wb_rd_i[gi*LA +: LA];
            e.data = wb_data_i[gi*LR +: LR];
            sb_q.push_back(e);
            ptr_m = gi;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag, input int cnt);
        check({tag, " count"}, 64'(dut.out_cnt), 64'(cnt));
        check({tag, " busy_o"}, 64'(busy_o), 64'(cnt != 0));
    endtask

    logic [NW-1:0] exp_g [4] = '{2'b10, 2'b01, 2'b10, 2'b01};

    initial begin
        rst = 1'b0;
        set_iss(1'b0, '0, '0, '0, 1'b0);
        reserve_i  = '0;
        wb_valid_i = '0;
        wb_rd_i    = '0;
        wb_data_i  = '0;
        drain_i    = 1'b0;
        ptr_m      = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset state
        check("reset wb_o", 64'(wb_o), 64'd0);
        check("reset wb_data_o", 64'(wb_data_o), 64'd0);
        check("reset drained_o", 64'(drained_o), 64'd0);
        check("reset state", 64'(dut.state), 64'd0);
        check_cnt("reset", 0);

        // Plain issue of rd=3
        set_iss(1'b1, 4'd0, 4'd0, 4'd3, 1'b1);
        settle("t1");
        check("t1 iss_ready_o", 64'(iss_ready_o), 64'd1);
        check("t1 w_reserve_o", 64'(w_reserve_o), 64'h0008);
        advance();
        check_cnt("t1", 1);

        // Hazard probes with r3 reserved, plus a writeback of r3 from source 0
        reserve_i = 16'h0008;
        set_wb(0, 1'b1, 4'd3, 32'hDEADBEEF);
        set_iss(1'b1, 4'd3, 4'd0, 4'd0, 1'b0);
        #1 check("raw rs0 iss_ready_o", 64'(iss_ready_o), 64'd0);
        set_iss(1'b1, 4'd0, 4'd3, 4'd0, 1'b0);
        #1 check("raw rs1 iss_ready_o", 64'(iss_ready_o), 64'd0);
        set_iss(1'b1, 4'd0, 4'd0, 4'd3, 1'b1);
        #1 check("waw iss_ready_o", 64'(iss_ready_o), 64'd0);
        set_iss(1'b1, 4'd3, 4'd0, 4'd0, 1'b0);
        settle("t2");
        check("t2 wb_ready_o src0", 64'(wb_ready_o), 64'b01);
        check("t2 w_reserve_o", 64'(w_reserve_o), 64'h0);
        advance();

        // Writeback in flight: r3 still reserved; rd=3 without rd_en is not a hazard
        set_wb(0, 1'b0, 4'd0, 32'h0);
        #1 check("inflight raw iss_ready_o", 64'(iss_ready_o), 64'd0);
        set_iss(1'b1, 4'd0, 4'd0, 4'd3, 1'b0);
        settle("t3");
        check("no-rd_en iss_ready_o", 64'(iss_ready_o), 64'd1);
        check("no-rd_en w_reserve_o", 64'(w_reserve_o), 64'h0);
        check_cnt("t3 before", 1);
        advance();
        check_cnt("t3 after", 0);
        reserve_i = '0;
        set_iss(1'b0, '0, '0, '0, 1'b0);

        // Both sources requesting for four cycles: grants alternate
        for (int c = 0; c < 4; c++) begin
            set_wb(0, 1'b1, 4'd1, 32'h1000_0000 + 32'(c));
            set_wb(1, 1'b1, 4'd2, 32'h2000_0000 + 32'(c));
            settle("rr");
            check("rr grant order", 64'(wb_ready_o), 64'(exp_g[c]));
            advance();
            check_cnt("rr", 0);
        end
        set_wb(0, 1'b0, 4'd0, 32'h0);
        set_wb(1, 1'b0, 4'd0, 32'h0);
        settle("rr tail");
        advance();

        // Drain with two reservations outstanding
        set_iss(1'b1, 4'd0, 4'd0, 4'd1, 1'b1);
        settle("dA");
        check("dA w_reserve_o", 64'(w_reserve_o), 64'h0002);
        advance();
        reserve_i = 16'h0002;
        set_iss(1'b1, 4'd0, 4'd0, 4'd2, 1'b1);
        settle("dB");
        check("dB w_reserve_o", 64'(w_reserve_o), 64'h0004);
        advance();
        check_cnt("dB", 2);
        reserve_i = 16'h0006;
        set_iss(1'b0, '0, '0, '0, 1'b0);
        drain_i = 1'b1;
        settle("dC");
        check("dC drained_o", 64'(drained_o), 64'd0);
        advance();
        drain_i = 1'b0;
        check("dC state", 64'(dut.state), 64'd1);
        set_iss(1'b1, 4'd0, 4'd0, 4'd7, 1'b1);
        set_wb(0, 1'b1, 4'd1, 32'hA1A1_A1A1);
        settle("dD");
        check("dD iss_ready_o", 64'(iss_ready_o), 64'd0);
        check("dD w_reserve_o", 64'(w_reserve_o), 64'h0);
        advance();
        check_cnt("dD", 2);
        reserve_i = 16'h0004;
        set_wb(0, 1'b0, 4'd0, 32'h0);
        set_wb(1, 1'b1, 4'd2, 32'hB2B2_B2B2);
        settle("dE");
        check("dE drained_o", 64'(drained_o), 64'd0);
        advance();
        check_cnt("dE", 1);
        set_wb(1, 1'b0, 4'd0, 32'h0);
        settle("dF");
        check("dF drained_o", 64'(drained_o), 64'd0);
        advance();
        check_cnt("dF", 0);
        reserve_i = '0;
        settle("dG");
        check("dG drained_o", 64'(drained_o), 64'd1);
        check("dG iss_ready_o", 64'(iss_ready_o), 64'd0);
        advance();
        set_iss(1'b1, 4'd0, 4'd0, 4'd7, 1'b0);
        settle("dH");
        check("dH state", 64'(dut.state), 64'd0);
        check("dH drained_o", 64'(drained_o), 64'd0);
        check("dH iss_ready_o", 64'(iss_ready_o), 64'd1);
        advance();

        // Drain with nothing outstanding completes on the next cycle
        set_iss(1'b0, '0, '0, '0, 1'b0);
        drain_i = 1'b1;
        settle("eI");
        check("eI drained_o", 64'(drained_o), 64'd0);
        advance();
        drain_i = 1'b0;
        settle("eJ");
        check("eJ drained_o", 64'(drained_o), 64'd1);
        advance();
        settle("eK");
        check("eK drained_o", 64'(drained_o), 64'd0);
        check("eK state", 64'(dut.state), 64'd0);
        advance();

        // Issue reserving r5 in the same cycle wb_o writes r2
        set_iss(1'b1, 4'd0, 4'd0, 4'd2, 1'b1);
        settle("sL");
        advance();
        check_cnt("sL", 1);
        reserve_i = 16'h0004;
        set_iss(1'b0, '0, '0, '0, 1'b0);
        set_wb(0, 1'b1, 4'd2, 32'hC3C3_C3C3);
        settle("sM");
        advance();
        set_wb(0, 1'b0, 4'd0, 32'h0);
        set_iss(1'b1, 4'd0, 4'd0, 4'd2, 1'b1);
        #1 check("sN rd in wb iss_ready_o", 64'(iss_ready_o), 64'd0);
        set_iss(1'b1, 4'd0, 4'd0, 4'd5, 1'b1);
        settle("sN");
        check("sN iss_ready_o", 64'(iss_ready_o), 64'd1);
        check("sN w_reserve_o", 64'(w_reserve_o), 64'h0020);
        advance();
        check_cnt("sN", 1);
        reserve_i = 16'h0020;
        set_iss(1'b0, '0, '0, '0, 1'b0);
        set_wb(1, 1'b1, 4'd5, 32'hD4D4_D4D4);
        settle("sO");
        advance();
        set_wb(1, 1'b0, 4'd0, 32'h0);
        settle("sP");
        advance();
        check_cnt("sP", 0);
        // Writeback to an unreserved register at count 0
        reserve_i = '0;
        set_wb(0, 1'b1, 4'd9, 32'hE5E5_E5E5);
        settle("sQ");
        advance();
        set_wb(0, 1'b0, 4'd0, 32'h0);
        settle("sR");
        advance();
        check_cnt("sR", 0);

        // Reset mid-drain with the stage holding a writeback
        set_iss(1'b1, 4'd0, 4'd0, 4'd4, 1'b1);
        settle("rS");
        advance();
        set_iss(1'b0, '0, '0, '0, 1'b0);
        reserve_i = 16'h0010;
        drain_i   = 1'b1;
        set_wb(0, 1'b1, 4'd4, 32'hF6F6_F6F6);
        settle("rT");
        advance();
        drain_i = 1'b0;
        set_wb(0, 1'b0, 4'd0, 32'h0);
        check("rT pre wb_o", 64'(wb_o), 64'h0010);
        check("rT pre state", 64'(dut.state), 64'd1);
        sb_q.delete();
        #1 rst = 1'b0;
        #1;
        check("rst wb_o", 64'(wb_o), 64'd0);
        check("rst wb_data_o", 64'(wb_data_o), 64'd0);
        check("rst state", 64'(dut.state), 64'd0);
        check("rst drained_o", 64'(drained_o), 64'd0);
        check_cnt("rst", 0);
        ptr_m     = 0;
        reserve_i = '0;
        #1 rst = 1'b1;
        advance();

        // Pointer back to 0 after reset: source 1 wins first
        set_wb(0, 1'b1, 4'd6, 32'h0606_0606);
        set_wb(1, 1'b1, 4'd7, 32'h0707_0707);
        settle("pU");
        check("pU grant after reset", 64'(wb_ready_o), 64'b10);
        advance();
        set_wb(0, 1'b0, 4'd0, 32'h0);
        set_wb(1, 1'b0, 4'd0, 32'h0);
        settle("pV");
        advance();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
